// File: rtl/count_seq_checker.sv
// ============================================================================
// Module   : count_seq_checker
// Purpose  : Locks onto an incrementing modulo-2^WIDTH count stream and flags,
//            counts and records every sample that breaks the sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_checker #(
   parameter int WIDTH     = 4,
   parameter int SYNC_LEN  = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [WIDTH-1:0]     count,
   input  logic                 clr_err,
   output logic                 locked,
   output logic [WIDTH-1:0]     expected,
   output logic                 err_pulse,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [ERR_CNT_W-1:0] wrap_count,
   output logic [WIDTH-1:0]     last_bad
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SYNCING  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]     c_one      = WIDTH'(1);
   localparam logic [WIDTH-1:0]     c_cnt_top  = '1;
   localparam logic [3:0]           c_sync_len = 4'(SYNC_LEN);
   localparam logic [ERR_CNT_W-1:0] c_sat_max  = '1;
   localparam logic [ERR_CNT_W-1:0] c_sat_one  = ERR_CNT_W'(1);

   state_t                 r_state;
   logic [WIDTH-1:0]       r_prev;
   logic [3:0]             r_match;
   logic [WIDTH-1:0]       r_expected;
   logic                   r_err_pulse;
   logic                   r_err_sticky;
   logic [ERR_CNT_W-1:0]   r_err_count;
   logic [ERR_CNT_W-1:0]   r_wrap_count;
   logic [WIDTH-1:0]       r_last_bad;

   state_t                 w_state_nxt;
   logic [WIDTH-1:0]       w_prev_nxt;
   logic [3:0]             w_match_nxt;
   logic                   w_seq_ok;
   logic                   w_mismatch;
   logic                   w_wrap;
   logic [ERR_CNT_W-1:0]   w_err_base;
   logic [ERR_CNT_W-1:0]   w_wrap_base;
   logic [ERR_CNT_W-1:0]   w_err_cnt_nxt;
   logic [ERR_CNT_W-1:0]   w_wrap_cnt_nxt;
   logic                   w_sticky_nxt;
   logic [WIDTH-1:0]       w_last_bad_nxt;

   assign w_seq_ok = (count == (r_prev + c_one));

   always_comb begin
      w_state_nxt = r_state;
      w_prev_nxt  = r_prev;
      w_match_nxt = r_match;
      w_mismatch  = 1'b0;
      w_wrap      = 1'b0;
      if (en) begin
         w_prev_nxt = count;
         case (r_state)
            ST_UNLOCKED: begin
               w_match_nxt = 4'd0;
               w_state_nxt = ST_SYNCING;
            end
            ST_SYNCING: begin
               if (w_seq_ok) begin
                  w_match_nxt = r_match + 4'd1;
                  if ((r_match + 4'd1) == c_sync_len)
                     w_state_nxt = ST_LOCKED;
               end else begin
                  w_match_nxt = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (w_seq_ok) begin
                  w_wrap = (r_prev == c_cnt_top);
               end else begin
                  w_mismatch  = 1'b1;
                  w_match_nxt = 4'd0;
                  w_state_nxt = ST_SYNCING;
               end
            end
            default: w_state_nxt = ST_UNLOCKED;
         endcase
      end
   end

   // Clear is applied first so a coinciding event lands on top of it.
   always_comb begin
      w_err_base     = clr_err ? '0 : r_err_count;
      w_wrap_base    = clr_err ? '0 : r_wrap_count;
      w_err_cnt_nxt  = (w_mismatch && (w_err_base != c_sat_max)) ? w_err_base + c_sat_one : w_err_base;
      w_wrap_cnt_nxt = (w_wrap && (w_wrap_base != c_sat_max)) ? w_wrap_base + c_sat_one : w_wrap_base;
      w_sticky_nxt   = w_mismatch | (r_err_sticky & ~clr_err);
      w_last_bad_nxt = w_mismatch ? count : (clr_err ? '0 : r_last_bad);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_UNLOCKED;
         r_prev       <= '0;
         r_match      <= 4'd0;
         r_expected   <= c_one;
         r_err_pulse  <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
         r_wrap_count <= '0;
         r_last_bad   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev       <= w_prev_nxt;
         r_match      <= w_match_nxt;
         r_expected   <= w_prev_nxt + c_one;
         r_err_pulse  <= w_mismatch;
         r_err_sticky <= w_sticky_nxt;
         r_err_count  <= w_err_cnt_nxt;
         r_wrap_count <= w_wrap_cnt_nxt;
         r_last_bad   <= w_last_bad_nxt;
      end
   end

   assign locked     = (r_state == ST_LOCKED);
   assign expected   = r_expected;
   assign err_pulse  = r_err_pulse;
   assign err_sticky = r_err_sticky;
   assign err_count  = r_err_count;
   assign wrap_count = r_wrap_count;
   assign last_bad   = r_last_bad;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
// ============================================================================
// Module   : tb_count_seq_checker
// Purpose  : Directed vector table plus hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       clr_err = 1'b0;
   logic [3:0] count = 4'd0;

   logic       locked, err_pulse, err_sticky;
   logic [3:0] expected, last_bad;
   logic [7:0] err_count, wrap_count;

   logic       s_locked, s_err_pulse, s_err_sticky;
   logic [3:0] s_expected, s_last_bad;
   logic [1:0] s_err_count, s_wrap_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .count(count), .clr_err(clr_err),
      .locked(locked), .expected(expected), .err_pulse(err_pulse),
      .err_sticky(err_sticky), .err_count(err_count),
      .wrap_count(wrap_count), .last_bad(last_bad)
   );

   count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .count(count), .clr_err(clr_err),
      .locked(s_locked), .expected(s_expected), .err_pulse(s_err_pulse),
      .err_sticky(s_err_sticky), .err_count(s_err_count),
      .wrap_count(s_wrap_count), .last_bad(s_last_bad)
   );

   typedef struct {
      logic       rst, en, clr;
      logic [3:0] cnt;
      logic       lk;
      logic [3:0] ex;
      logic       pl, st;
      logic [7:0] ec, wc;
      logic [3:0] lb;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int r, e, c, cnt, lk, ex, pl, st, ec, wc, lb);
      vec_t v;
      v.rst = 1'(r);  v.en = 1'(e);   v.clr = 1'(c);  v.cnt = 4'(cnt);
      v.lk  = 1'(lk); v.ex = 4'(ex);  v.pl  = 1'(pl); v.st  = 1'(st);
      v.ec  = 8'(ec); v.wc = 8'(wc);  v.lb  = 4'(lb);
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive on the falling edge, then sample just after the following rising edge.
   task automatic step(input logic r, input logic e, input logic c, input logic [3:0] cnt);
      @(negedge clk);
      rst = r; en = e; clr_err = c; count = cnt;
      @(posedge clk);
      #1;
   endtask

   task automatic sync_lock(input logic [3:0] start);
      step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b0, start);
      step(1'b0, 1'b1, 1'b0, start + 4'd1);
      step(1'b0, 1'b1, 1'b0, start + 4'd2);
   endtask

   initial begin
      logic [3:0] prev, v;

      //  rst en clr cnt | lk ex pl st ec wc lb
      add(1, 0, 0,  0,   0,  1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 11,   0, 12, 0, 0, 0, 0, 0);
      add(0, 1, 0, 12,   0, 13, 0, 0, 0, 0, 0);
      add(0, 1, 0, 13,   1, 14, 0, 0, 0, 0, 0);
      add(0, 1, 0, 14,   1, 15, 0, 0, 0, 0, 0);
      add(0, 1, 0, 15,   1,  0, 0, 0, 0, 0, 0);
      add(0, 1, 0,  0,   1,  1, 0, 0, 0, 1, 0);
      add(0, 1, 0,  1,   1,  2, 0, 0, 0, 1, 0);
      add(0, 1, 0,  2,   1,  3, 0, 0, 0, 1, 0);
      add(0, 1, 0,  3,   1,  4, 0, 0, 0, 1, 0);
      add(0, 1, 0,  4,   1,  5, 0, 0, 0, 1, 0);
      add(0, 1, 0,  5,   1,  6, 0, 0, 0, 1, 0);
      add(0, 1, 0,  7,   0,  8, 1, 1, 1, 1, 7);
      add(0, 1, 0,  8,   0,  9, 0, 1, 1, 1, 7);
      add(0, 1, 0,  9,   1, 10, 0, 1, 1, 1, 7);
      add(0, 0, 0,  3,   1, 10, 0, 1, 1, 1, 7);
      add(0, 0, 1,  6,   1, 10, 0, 0, 0, 0, 0);
      add(0, 1, 0, 10,   1, 11, 0, 0, 0, 0, 0);
      add(0, 1, 0, 10,   0, 11, 1, 1, 1, 0, 10);
      add(1, 1, 0,  3,   0,  1, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].cnt);
         check($sformatf("vec%0d.locked", i),     int'(locked),     int'(vecs[i].lk));
         check($sformatf("vec%0d.expected", i),   int'(expected),   int'(vecs[i].ex));
         check($sformatf("vec%0d.err_pulse", i),  int'(err_pulse),  int'(vecs[i].pl));
         check($sformatf("vec%0d.err_sticky", i), int'(err_sticky), int'(vecs[i].st));
         check($sformatf("vec%0d.err_count", i),  int'(err_count),  int'(vecs[i].ec));
         check($sformatf("vec%0d.wrap_count", i), int'(wrap_count), int'(vecs[i].wc));
         check($sformatf("vec%0d.last_bad", i),   int'(last_bad),   int'(vecs[i].lb));
      end

      // Enable gating: random count changes while en=0 are ignored.
      sync_lock(4'd2);
      check("gate.locked_start", int'(locked), 1);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 1'b0, 4'($urandom_range(15)));
         check("gate.locked_hold", int'(locked), 1);
         check("gate.no_pulse", int'(err_pulse), 0);
         check("gate.expected_hold", int'(expected), 5);
      end
      step(1'b0, 1'b1, 1'b0, 4'd5);
      check("gate.locked_after", int'(locked), 1);
      check("gate.pulse_after", int'(err_pulse), 0);
      check("gate.err_count", int'(err_count), 0);
      check("gate.expected_after", int'(expected), 6);

      // Saturation and clear-coincident mismatch.
      sync_lock(4'd0);
      prev = 4'd2;
      for (int k = 0; k < 5; k++) begin
         v = prev + 4'd2;
         step(1'b0, 1'b1, 1'b0, v);
         check("sat.pulse", int'(err_pulse), 1);
         check("sat.locked_drop", int'(locked), 0);
         check("sat.err_count_w8", int'(err_count), k + 1);
         check("sat.err_count_w2", int'(s_err_count), (k + 1 > 3) ? 3 : k + 1);
         check("sat.last_bad", int'(last_bad), int'(v));
         step(1'b0, 1'b1, 1'b0, v + 4'd1);
         check("sat.pulse_clear", int'(err_pulse), 0);
         step(1'b0, 1'b1, 1'b0, v + 4'd2);
         check("sat.relock", int'(locked), 1);
         prev = v + 4'd2;
      end
      check("sat.err_count_final", int'(s_err_count), 3);
      v = prev + 4'd3;
      step(1'b0, 1'b1, 1'b1, v);
      check("clr_mm.err_count_w2", int'(s_err_count), 1);
      check("clr_mm.err_count_w8", int'(err_count), 1);
      check("clr_mm.sticky", int'(s_err_sticky), 1);
      check("clr_mm.last_bad", int'(s_last_bad), int'(v));
      check("clr_mm.pulse", int'(s_err_pulse), 1);

      // Reset mid-operation after a wrap and two errors.
      sync_lock(4'd13);
      step(1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b0, 4'd5);
      step(1'b0, 1'b1, 1'b0, 4'd6);
      step(1'b0, 1'b1, 1'b0, 4'd7);
      step(1'b0, 1'b1, 1'b0, 4'd9);
      step(1'b0, 1'b1, 1'b0, 4'd10);
      step(1'b0, 1'b1, 1'b0, 4'd11);
      check("rstmid.pre_locked", int'(locked), 1);
      check("rstmid.pre_err_count", int'(err_count), 2);
      check("rstmid.pre_wrap_count", int'(wrap_count), 1);
      step(1'b1, 1'b1, 1'b0, 4'd12);
      check("rstmid.locked", int'(locked), 0);
      check("rstmid.err_count", int'(err_count), 0);
      check("rstmid.wrap_count", int'(wrap_count), 0);
      check("rstmid.sticky", int'(err_sticky), 0);
      check("rstmid.expected", int'(expected), 1);
      step(1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b0, 4'd1);
      check("resync.not_yet", int'(locked), 0);
      step(1'b0, 1'b1, 1'b0, 4'd2);
      check("resync.locked", int'(locked), 1);
      check("resync.expected", int'(expected), 3);
      check("resync.err_count", int'(err_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
